mem_data_lsu: RTL and testbench

//  Load/store unit between the RV32E core's MEM stage and the byte-addressable data RAM port
//  (addr_bus / write_data_bus / write_signal / read_data_bus).

---
 rtl/mem_data_lsu.sv | 150 +++++++++++++++
 tb/tb_mem_data_lsu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_data_lsu.sv
// Load/store unit between the core MEM stage and a big-endian, word-wide data RAM port.
// Sub-word stores are read-modify-write; every RAM write gets a registered setup/strobe/hold pulse.
module mem_data_lsu #(
    parameter int unsigned MEM_BYTES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] addr_bus,
    output logic [31:0] write_data_bus,
    output logic        write_signal,
    input  logic [31:0] read_data_bus
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } state_t;

    localparam logic [31:0] LastAddr = 32'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wbus_q, wbus_d;
    logic        wsig_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] load_value;

    // The addressed byte/half sits in the top bits of the RAM word (big-endian).
    always_comb begin
        load_value = read_data_bus;
        case (size_q)
            2'b00:   load_value = {{24{~uns_q & read_data_bus[31]}}, read_data_bus[31:24]};
            2'b01:   load_value = {{16{~uns_q & read_data_bus[31]}}, read_data_bus[31:16]};
            default: load_value = read_data_bus;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        wbus_d  = wbus_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata[15:0];
                    rdata_d = '0;
                    if (req_size == 2'b11 || req_addr > LastAddr) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d  = 1'b0;
                        addr_d = req_addr;
                        if (req_we && req_size == 2'b10) begin
                            wbus_d  = req_wdata;
                            state_d = SETUP;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    wbus_d  = (size_q == 2'b00) ? {wdata_q[7:0], read_data_bus[23:0]}
                                                : {wdata_q[15:0], read_data_bus[15:0]};
                    state_d = SETUP;
                end else begin
                    rdata_d = load_value;
                    state_d = RESP;
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: state_d = HOLD;
            HOLD:   state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobe is registered from the next state so it is glitch-free and aligned with STROBE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
            wbus_q  <= '0;
            wsig_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            wbus_q  <= wbus_d;
            wsig_q  <= (state_d == STROBE);
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = (state_q == RESP);
    assign resp_rdata     = rdata_q;
    assign resp_err       = err_q;
    assign addr_bus       = addr_q;
    assign write_data_bus = wbus_q;
    assign write_signal   = wsig_q;

endmodule

// File: tb/tb_mem_data_lsu.sv
// Randomized self-checking bench for mem_data_lsu against a byte-array model of memory.
// A behavioural RAM sits on the bus; a separate reference byte array predicts every result.
module tb_mem_data_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] addr_bus;
    logic [31:0] write_data_bus;
    logic        write_signal;
    logic [31:0] read_data_bus;

    int checkCount = 0;
    int errorCount = 0;
    int strobeCount = 0;

    logic [7:0] ram    [0:99];
    logic [7:0] refMem [0:99];
    logic [6:0] ramIdx;

    mem_data_lsu #(.MEM_BYTES(100)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .addr_bus(addr_bus),
        .write_data_bus(write_data_bus),
        .write_signal(write_signal),
        .read_data_bus(read_data_bus)
    );

    always #5 clk = ~clk;

    // Combinational RAM read port, big-endian: lowest address in the top byte.
    always_comb begin
        ramIdx        = addr_bus[6:0];
        read_data_bus = '0;
        if (addr_bus <= 32'd96)
            read_data_bus = {ram[ramIdx], ram[ramIdx + 7'd1], ram[ramIdx + 7'd2], ram[ramIdx + 7'd3]};
    end

    // RAM contents start random and are written on each write_signal rising edge.
    initial begin
        for (int i = 0; i < 100; i++) ram[i] = 8'($urandom);
        forever begin
            @(posedge write_signal);
            strobeCount++;
            if (addr_bus <= 32'd96) begin
                ram[ramIdx]        = write_data_bus[31:24];
                ram[ramIdx + 7'd1] = write_data_bus[23:16];
                ram[ramIdx + 7'd2] = write_data_bus[15:8];
                ram[ramIdx + 7'd3] = write_data_bus[7:0];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStore(input logic [1:0] size, input int a, input logic [31:0] wdata);
        case (size)
            2'b00: refMem[a] = wdata[7:0];
            2'b01: begin
                refMem[a]     = wdata[15:8];
                refMem[a + 1] = wdata[7:0];
            end
            default: begin
                refMem[a]     = wdata[31:24];
                refMem[a + 1] = wdata[23:16];
                refMem[a + 2] = wdata[15:8];
                refMem[a + 3] = wdata[7:0];
            end
        endcase
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int stall);
        logic        isErr;
        logic [31:0] expRd;
        logic [15:0] half;
        int          expLat, expWrites, lat, strobes0, a;
        isErr     = (size == 2'b11) || (addr > 32'd96);
        a         = isErr ? 0 : int'(addr);
        expRd     = '0;
        expWrites = 0;
        if (isErr) expLat = 1;
        else if (we) begin
            expWrites = 1;
            expLat    = (size == 2'b10) ? 4 : 5;
        end else begin
            expLat = 2;
            half   = {refMem[a], refMem[a + 1]};
            case (size)
                2'b00:   expRd = uns ? 32'(refMem[a]) : int'($signed(refMem[a]));
                2'b01:   expRd = uns ? 32'(half) : int'($signed(half));
                default: expRd = {refMem[a], refMem[a + 1], refMem[a + 2], refMem[a + 3]};
            endcase
        end
        strobes0 = strobeCount;
        @(negedge clk);
        checkOutput("req_ready_idle", req_ready, 1'b1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        resp_ready   = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("resp_err", resp_err, isErr);
        checkOutput("resp_rdata", resp_rdata, expRd);
        if (stall > 0) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_size  = 2'b10;
            req_addr  = 32'd0;
            req_wdata = $urandom;
            repeat (stall) begin
                @(posedge clk);
                #1;
                checkOutput("stall_valid", resp_valid, 1'b1);
                checkOutput("stall_rdata", resp_rdata, expRd);
                checkOutput("stall_ready", req_ready, 1'b0);
            end
            req_valid = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        checkOutput("resp_clear", resp_valid, 1'b0);
        checkOutput("write_count", 32'(strobeCount - strobes0), 32'(expWrites));
        if (we && !isErr) modelStore(size, a, wdata);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          strobes0, diffs, stall;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        resp_ready   = 1'b0;
        #1;
        for (int i = 0; i < 100; i++) refMem[i] = ram[i];
        #11;
        checkOutput("rst_req_ready", req_ready, 1'b1);
        checkOutput("rst_resp_valid", resp_valid, 1'b0);
        checkOutput("rst_rdata", resp_rdata, 32'd0);
        checkOutput("rst_addr_bus", addr_bus, 32'd0);
        checkOutput("rst_wdata_bus", write_data_bus, 32'd0);
        checkOutput("rst_write_signal", write_signal, 1'b0);
        @(negedge clk) rst = 1'b0;

        // Directed sequence
        applyStimulus(1'b1, 2'b10, 1'b0, 32'd8, 32'h11223344, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd8, 32'd0, 0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'd9, 32'h000000AA, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd9, 32'd0, 0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'd9, 32'd0, 0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'd9, 32'd0, 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'd4, 32'h0000005A, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd97, 32'd0, 0);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'd20, 32'hDEADBEEF, 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'hFFFFFFFF, 32'hCAFEF00D, 0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'd96, 32'h0000BEEF, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd96, 32'd0, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 3);

        // Reset during SETUP of a byte store: nothing is written
        strobes0 = strobeCount;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr  = 32'd12; req_wdata = $urandom;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rstmid_resp_valid", resp_valid, 1'b0);
        checkOutput("rstmid_addr_bus", addr_bus, 32'd0);
        checkOutput("rstmid_wdata_bus", write_data_bus, 32'd0);
        checkOutput("rstmid_write_signal", write_signal, 1'b0);
        checkOutput("rstmid_req_ready", req_ready, 1'b1);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkOutput("rstmid_no_write", 32'(strobeCount - strobes0), 32'd0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd12, 32'd0, 0);

        // Reset during STROBE of a word store: the write stands, no response follows
        strobes0 = strobeCount;
        wdata    = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'd16; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rststb_write_signal", write_signal, 1'b0);
        checkOutput("rststb_resp_valid", resp_valid, 1'b0);
        modelStore(2'b10, 16, wdata);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rststb_write_kept", 32'(strobeCount - strobes0), 32'd1);
        checkOutput("rststb_no_resp", resp_valid, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd16, 32'd0, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            addr  = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 99));
            wdata = $urandom;
            stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            applyStimulus(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, wdata, stall);
        end

        diffs = 0;
        for (int i = 0; i < 100; i++) if (ram[i] !== refMem[i]) diffs++;
        checkOutput("mem_final_diffs", 32'(diffs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
